// File: rtl/csr_commit_ctrl_pkg.sv
// Shared CSR-port encodings for the WB commit controller: CSR op codes, exception
// codes, architectural CSR numbers and the commit FSM state type.
package csr_commit_ctrl_pkg;

  localparam logic [1:0] CSR_OP_NONE = 2'd0;
  localparam logic [1:0] CSR_OP_RD   = 2'd1;
  localparam logic [1:0] CSR_OP_WR   = 2'd2;
  localparam logic [1:0] CSR_OP_XCHG = 2'd3;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_KILL = 1'b1
  } state_t;

  function automatic logic csr_op_writes(input logic [1:0] op);
    return (op == CSR_OP_WR) || (op == CSR_OP_XCHG);
  endfunction

endpackage

// File: rtl/csr_commit_ctrl_if.sv
// MEM->WB handshake, CSR-file port and commit/redirect signals of the WB commit controller.
// master = the commit controller, slave = the surrounding pipeline and CSR file.
interface csr_commit_ctrl_if #(
  parameter int CSR_NUM_W = 14
);
  logic                 ms_to_ws_valid;
  logic                 ws_allow_in;
  logic [31:0]          ms_pc;
  logic [1:0]           ms_csr_op;
  logic [CSR_NUM_W-1:0] ms_csr_num;
  logic [31:0]          ms_rj_value;
  logic [31:0]          ms_rkd_value;
  logic                 ms_ertn;
  logic                 ms_ex;
  logic [5:0]           ms_ecode;
  logic [8:0]           ms_esubcode;
  logic                 ms_rf_we;

  logic                 has_int;
  logic [31:0]          csr_rvalue;
  logic [31:0]          ex_entry;
  logic [31:0]          ertn_entry;

  logic                 csr_re;
  logic [CSR_NUM_W-1:0] csr_rnum;
  logic                 csr_we;
  logic [31:0]          csr_wmask;
  logic [CSR_NUM_W-1:0] csr_wnum;
  logic [31:0]          csr_wvalue;

  logic                 wb_ex;
  logic [5:0]           wb_ecode;
  logic [8:0]           wb_esubcode;
  logic [31:0]          wb_pc;
  logic                 eret_flush;
  logic                 flush_valid;
  logic [31:0]          flush_target;
  logic                 rf_we;
  logic [31:0]          rf_wdata_csr;
  logic                 ws_csr_busy;
  logic [31:0]          ex_count;

  modport master (
    input  ms_to_ws_valid, ms_pc, ms_csr_op, ms_csr_num, ms_rj_value, ms_rkd_value,
           ms_ertn, ms_ex, ms_ecode, ms_esubcode, ms_rf_we,
           has_int, csr_rvalue, ex_entry, ertn_entry,
    output ws_allow_in, csr_re, csr_rnum, csr_we, csr_wmask, csr_wnum, csr_wvalue,
           wb_ex, wb_ecode, wb_esubcode, wb_pc, eret_flush, flush_valid, flush_target,
           rf_we, rf_wdata_csr, ws_csr_busy, ex_count
  );

  modport slave (
    output ms_to_ws_valid, ms_pc, ms_csr_op, ms_csr_num, ms_rj_value, ms_rkd_value,
           ms_ertn, ms_ex, ms_ecode, ms_esubcode, ms_rf_we,
           has_int, csr_rvalue, ex_entry, ertn_entry,
    input  ws_allow_in, csr_re, csr_rnum, csr_we, csr_wmask, csr_wnum, csr_wvalue,
           wb_ex, wb_ecode, wb_esubcode, wb_pc, eret_flush, flush_valid, flush_target,
           rf_we, rf_wdata_csr, ws_csr_busy, ex_count
  );
endinterface

// File: rtl/csr_commit_ctrl.sv
// WB-stage commit controller: turns each retiring instruction into CSR requests, precise
// exception / ertn commit pulses and a front-end redirect, then kills wrong-path arrivals.
module csr_commit_ctrl
  import csr_commit_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CSR_NUM_W    = 14
) (
  input  logic              clk,
  input  logic              resetn,
  csr_commit_ctrl_if.master bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     kill_cnt, kill_cnt_nxt;
  logic [31:0]          ex_count_q;

  logic                 vld_p1;
  logic [31:0]          pc_p1;
  logic [1:0]           op_p1;
  logic [CSR_NUM_W-1:0] num_p1;
  logic [31:0]          rj_p1;
  logic [31:0]          rkd_p1;
  logic                 ertn_p1;
  logic                 ex_p1;
  logic [5:0]           ecode_p1;
  logic [8:0]           esub_p1;
  logic                 rf_we_p1;

  logic capture;
  logic drop;
  logic commit;
  logic ex_final;
  logic take_ex;
  logic take_ertn;
  logic csr_wr_op;
  logic rd_c;
  logic wr_c;

  assign bus.ws_allow_in = 1'b1;
  assign capture         = bus.ms_to_ws_valid & bus.ws_allow_in;
  assign bus.ex_count    = ex_count_q;

  // MEM -> WB boundary: a wrong-path arrival is latched as a bubble
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= capture & ~drop;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      pc_p1    <= bus.ms_pc;
      op_p1    <= bus.ms_csr_op;
      num_p1   <= bus.ms_csr_num;
      rj_p1    <= bus.ms_rj_value;
      rkd_p1   <= bus.ms_rkd_value;
      ertn_p1  <= bus.ms_ertn;
      ex_p1    <= bus.ms_ex;
      ecode_p1 <= bus.ms_ecode;
      esub_p1  <= bus.ms_esubcode;
      rf_we_p1 <= bus.ms_rf_we;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      kill_cnt   <= '0;
      ex_count_q <= '0;
    end else begin
      state    <= state_nxt;
      kill_cnt <= kill_cnt_nxt;
      if (take_ex) begin
        ex_count_q <= sat_inc(ex_count_q);
      end
    end
  end

  // WB commit: everything below is combinational from the WB register and CSR file
  always_comb begin
    state_nxt    = state;
    kill_cnt_nxt = kill_cnt;
    drop         = 1'b0;
    commit       = 1'b0;
    ex_final     = 1'b0;
    take_ex      = 1'b0;
    take_ertn    = 1'b0;
    rd_c         = 1'b0;
    wr_c         = 1'b0;
    csr_wr_op    = csr_op_writes(op_p1);

    bus.csr_re       = 1'b0;
    bus.csr_rnum     = '0;
    bus.csr_we       = 1'b0;
    bus.csr_wmask    = '0;
    bus.csr_wnum     = '0;
    bus.csr_wvalue   = '0;
    bus.wb_ex        = 1'b0;
    bus.wb_ecode     = '0;
    bus.wb_esubcode  = '0;
    bus.wb_pc        = '0;
    bus.eret_flush   = 1'b0;
    bus.flush_valid  = 1'b0;
    bus.flush_target = '0;
    bus.rf_we        = 1'b0;
    bus.rf_wdata_csr = '0;
    bus.ws_csr_busy  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        commit    = vld_p1;
        ex_final  = ex_p1 | bus.has_int;
        take_ex   = commit & ex_final;
        take_ertn = commit & ertn_p1 & ~ex_final;
        rd_c      = commit & (op_p1 != CSR_OP_NONE);
        wr_c      = commit & csr_wr_op & ~ex_final;

        bus.csr_re      = rd_c;
        bus.csr_we      = wr_c;
        bus.wb_ex       = take_ex;
        bus.eret_flush  = take_ertn;
        bus.flush_valid = take_ex | take_ertn;
        bus.rf_we       = commit & rf_we_p1 & ~ex_final;
        bus.ws_csr_busy = commit & (csr_wr_op | ertn_p1);

        if (commit) begin
          bus.wb_pc = pc_p1;
        end
        // CSR file updates at the edge, so the read returns the pre-write value for rd
        if (rd_c) begin
          bus.csr_rnum     = num_p1;
          bus.rf_wdata_csr = bus.csr_rvalue;
        end
        if (wr_c) begin
          bus.csr_wnum   = num_p1;
          bus.csr_wmask  = (op_p1 == CSR_OP_XCHG) ? rj_p1 : 32'hFFFF_FFFF;
          bus.csr_wvalue = rkd_p1;
        end
        // A pending interrupt overrides whatever the instruction raised upstream
        if (take_ex) begin
          bus.wb_ecode     = bus.has_int ? ECODE_INT : ecode_p1;
          bus.wb_esubcode  = bus.has_int ? 9'd0 : esub_p1;
          bus.flush_target = bus.ex_entry;
        end else if (take_ertn) begin
          bus.flush_target = bus.ertn_entry;
        end

        if (take_ex | take_ertn) begin
          state_nxt    = ST_KILL;
          kill_cnt_nxt = CNT_W'(FLUSH_CYCLES - 1);
          drop         = 1'b1;
        end
      end

      ST_KILL: begin
        if (kill_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          kill_cnt_nxt = kill_cnt - CNT_W'(1);
          drop         = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Bench for csr_commit_ctrl: directed commit scenarios plus randomized traffic against
// an arrival-counting reference model of the WB slot and wrong-path kill window.
module tb_csr_commit_ctrl;
  import csr_commit_ctrl_pkg::*;

  localparam int FLUSH = 2;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  csr_commit_ctrl_if #(.CSR_NUM_W(14)) bus();

  csr_commit_ctrl #(.FLUSH_CYCLES(FLUSH), .CSR_NUM_W(14)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [1:0]  op;
    logic [13:0] num;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic        ertn;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic        rf_we;
  } instr_t;

  instr_t      slot;
  int          drop_left;
  logic [31:0] exp_cnt;
  logic [31:0] cur_exe;
  logic [31:0] cur_erte;
  logic        cur_hi;
  logic [31:0] cur_rv;
  instr_t      cur_m;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, act, exp, $time);
  endtask

  function automatic instr_t idle_i();
    instr_t t;
    t = '{default: '0};
    return t;
  endfunction

  function automatic instr_t mk(input logic [31:0] pc, input logic [1:0] op, input logic [13:0] num,
                                input logic [31:0] rj, input logic [31:0] rkd, input logic ertn,
                                input logic ex, input logic [5:0] ec, input logic rfwe);
    instr_t t;
    t = '{v: 1'b1, pc: pc, op: op, num: num, rj: rj, rkd: rkd, ertn: ertn, ex: ex,
          ecode: ec, esub: 9'd0, rf_we: rfwe};
    return t;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t t;
    t.v     = ($urandom_range(0, 9) < 7);
    t.pc    = $urandom & 32'hFFFF_FFFC;
    t.op    = 2'($urandom_range(0, 3));
    t.num   = 14'($urandom_range(0, 63));
    t.rj    = $urandom;
    t.rkd   = $urandom;
    t.ertn  = ($urandom_range(0, 9) == 0);
    t.ex    = ($urandom_range(0, 9) == 0);
    t.ecode = 6'($urandom_range(0, 63));
    t.esub  = 9'($urandom_range(0, 511));
    t.rf_we = 1'($urandom_range(0, 1));
    return t;
  endfunction

  task automatic drive(input instr_t m, input logic hi, input logic [31:0] rv);
    bus.ms_to_ws_valid = m.v;
    bus.ms_pc          = m.pc;
    bus.ms_csr_op      = m.op;
    bus.ms_csr_num     = m.num;
    bus.ms_rj_value    = m.rj;
    bus.ms_rkd_value   = m.rkd;
    bus.ms_ertn        = m.ertn;
    bus.ms_ex          = m.ex;
    bus.ms_ecode       = m.ecode;
    bus.ms_esubcode    = m.esub;
    bus.ms_rf_we       = m.rf_we;
    bus.has_int        = hi;
    bus.csr_rvalue     = rv;
    bus.ex_entry       = cur_exe;
    bus.ertn_entry     = cur_erte;
  endtask

  // Drive one cycle's inputs at the falling edge and compare every output with the model
  task automatic drive_check(input instr_t m, input logic hi, input logic [31:0] rv);
    logic tex, ter, wr, re, we;
    @(negedge clk);
    cur_exe  = $urandom | 32'h1C00_0000;
    cur_erte = $urandom;
    cur_m = m; cur_hi = hi; cur_rv = rv;
    drive(m, hi, rv);
    #1;
    tex = slot.v && (slot.ex || hi);
    ter = slot.v && slot.ertn && !tex;
    wr  = slot.op inside {CSR_OP_WR, CSR_OP_XCHG};
    re  = slot.v && (slot.op != CSR_OP_NONE);
    we  = slot.v && wr && !tex;
    check("ws_allow_in", 32'(bus.ws_allow_in), 32'd1);
    check("csr_re", 32'(bus.csr_re), 32'(re));
    check("csr_rnum", 32'(bus.csr_rnum), re ? 32'(slot.num) : 32'd0);
    check("csr_we", 32'(bus.csr_we), 32'(we));
    check("csr_wnum", 32'(bus.csr_wnum), we ? 32'(slot.num) : 32'd0);
    check("csr_wmask", bus.csr_wmask, !we ? 32'd0 : (slot.op == CSR_OP_XCHG) ? slot.rj : 32'hFFFF_FFFF);
    check("csr_wvalue", bus.csr_wvalue, we ? slot.rkd : 32'd0);
    check("wb_ex", 32'(bus.wb_ex), 32'(tex));
    check("wb_ecode", 32'(bus.wb_ecode), !tex ? 32'd0 : hi ? 32'(ECODE_INT) : 32'(slot.ecode));
    check("wb_esubcode", 32'(bus.wb_esubcode), (tex && !hi) ? 32'(slot.esub) : 32'd0);
    check("wb_pc", bus.wb_pc, slot.v ? slot.pc : 32'd0);
    check("eret_flush", 32'(bus.eret_flush), 32'(ter));
    check("flush_valid", 32'(bus.flush_valid), 32'(tex || ter));
    check("flush_target", bus.flush_target, tex ? cur_exe : ter ? cur_erte : 32'd0);
    check("rf_we", 32'(bus.rf_we), 32'(slot.v && slot.rf_we && !tex));
    check("rf_wdata_csr", bus.rf_wdata_csr, re ? rv : 32'd0);
    check("ws_csr_busy", 32'(bus.ws_csr_busy), 32'(slot.v && (wr || slot.ertn)));
    check("ex_count", bus.ex_count, exp_cnt);
  endtask

  // Advance through the rising edge and move the model: a redirect drops the next FLUSH arrivals
  task automatic advance();
    logic tex, ter;
    @(posedge clk);
    tex = slot.v && (slot.ex || cur_hi);
    ter = slot.v && slot.ertn && !tex;
    if (tex && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    if (tex || ter) drop_left = FLUSH;
    slot   = cur_m;
    slot.v = cur_m.v && (drop_left == 0);
    if (drop_left > 0) drop_left--;
  endtask

  task automatic cycle(input instr_t m, input logic hi, input logic [31:0] rv);
    drive_check(m, hi, rv);
    advance();
  endtask

  task automatic reset_and_check(input string tag);
    @(negedge clk);
    cur_m = idle_i(); cur_hi = 1'b0; cur_rv = 32'd0;
    drive(cur_m, 1'b0, 32'd0);
    resetn = 1'b0;
    #1;
    slot = idle_i(); drop_left = 0; exp_cnt = 32'd0;
    check({tag, "_allow_in"}, 32'(bus.ws_allow_in), 32'd1);
    check({tag, "_wb_ex"}, 32'(bus.wb_ex), 32'd0);
    check({tag, "_flush_valid"}, 32'(bus.flush_valid), 32'd0);
    check({tag, "_csr_we"}, 32'(bus.csr_we), 32'd0);
    check({tag, "_rf_we"}, 32'(bus.rf_we), 32'd0);
    check({tag, "_ex_count"}, bus.ex_count, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    cur_exe = 32'h1C00_8000; cur_erte = 32'h1C00_0200;
    drive(idle_i(), 1'b0, 32'd0);
    reset_and_check("rst");

    // csrwr SAVE0: old value 0 goes to rd, full mask
    cycle(mk(32'h1C00_0000, CSR_OP_WR, CSR_SAVE0, 32'd0, 32'h1234_5678, 1'b0, 1'b0, 6'd0, 1'b1), 1'b0, 32'd5);
    drive_check(mk(32'h1C00_0004, CSR_OP_XCHG, CSR_CRMD, 32'h4, 32'h4, 1'b0, 1'b0, 6'd0, 1'b1), 1'b0, 32'd0);
    check("save0_we", 32'(bus.csr_we), 32'd1);
    check("save0_mask", bus.csr_wmask, 32'hFFFF_FFFF);
    check("save0_wvalue", bus.csr_wvalue, 32'h1234_5678);
    check("save0_rd", bus.rf_wdata_csr, 32'd0);
    check("save0_rf_we", 32'(bus.rf_we), 32'd1);
    advance();

    // csrxchg CRMD with mask 0x4
    drive_check(mk(32'h1C00_0100, CSR_OP_NONE, 14'd0, 32'd0, 32'd0, 1'b0, 1'b1, ECODE_SYS, 1'b1), 1'b0, 32'h8);
    check("xchg_we", 32'(bus.csr_we), 32'd1);
    check("xchg_mask", bus.csr_wmask, 32'h0000_0004);
    check("xchg_wvalue", bus.csr_wvalue, 32'h4);
    advance();

    // syscall commits; arrivals in this cycle and the next are wrong-path
    drive_check(mk(32'h1C00_0104, CSR_OP_WR, CSR_SAVE0, 32'd0, 32'hA, 1'b0, 1'b0, 6'd0, 1'b1), 1'b0, 32'd0);
    check("sys_wb_ex", 32'(bus.wb_ex), 32'd1);
    check("sys_wb_pc", bus.wb_pc, 32'h1C00_0100);
    check("sys_ecode", 32'(bus.wb_ecode), 32'(ECODE_SYS));
    check("sys_csr_we", 32'(bus.csr_we), 32'd0);
    check("sys_rf_we", 32'(bus.rf_we), 32'd0);
    check("sys_target", bus.flush_target, cur_exe);
    advance();
    drive_check(mk(32'h1C00_0108, CSR_OP_WR, CSR_SAVE0, 32'd0, 32'hB, 1'b0, 1'b0, 6'd0, 1'b1), 1'b1, 32'd0);
    check("kill1_rf_we", 32'(bus.rf_we), 32'd0);
    check("kill1_int_not_taken", 32'(bus.wb_ex), 32'd0);
    advance();
    drive_check(mk(32'h1C00_8000, CSR_OP_WR, CSR_SAVE0, 32'd0, 32'hC, 1'b0, 1'b0, 6'd0, 1'b1), 1'b0, 32'd0);
    check("kill2_csr_we", 32'(bus.csr_we), 32'd0);
    advance();
    drive_check(idle_i(), 1'b0, 32'd0);
    check("post_kill_we", 32'(bus.csr_we), 32'd1);
    check("post_kill_wvalue", bus.csr_wvalue, 32'hC);
    check("sys_ex_count", bus.ex_count, 32'd1);
    advance();

    // interrupt on a retiring csrwr
    cycle(mk(32'h1C00_8004, CSR_OP_WR, CSR_SAVE0, 32'd0, 32'h77, 1'b0, 1'b0, 6'd0, 1'b1), 1'b0, 32'd0);
    drive_check(idle_i(), 1'b1, 32'd3);
    check("int_wb_ex", 32'(bus.wb_ex), 32'd1);
    check("int_ecode", 32'(bus.wb_ecode), 32'd0);
    check("int_csr_we", 32'(bus.csr_we), 32'd0);
    check("int_rf_we", 32'(bus.rf_we), 32'd0);
    advance();
    cycle(idle_i(), 1'b0, 32'd0);
    cycle(idle_i(), 1'b0, 32'd0);

    // ertn, then ertn carrying an upstream exception
    cycle(mk(32'h1C00_8008, CSR_OP_NONE, 14'd0, 32'd0, 32'd0, 1'b1, 1'b0, 6'd0, 1'b0), 1'b0, 32'd0);
    drive_check(idle_i(), 1'b0, 32'd0);
    check("ertn_flush", 32'(bus.eret_flush), 32'd1);
    check("ertn_target", bus.flush_target, cur_erte);
    advance();
    cycle(mk(32'h1C00_0200, CSR_OP_NONE, 14'd0, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b0), 1'b0, 32'd0);
    cycle(mk(32'h1C00_0204, CSR_OP_NONE, 14'd0, 32'd0, 32'd0, 1'b1, 1'b1, ECODE_ADEF, 1'b0), 1'b0, 32'd0);
    drive_check(idle_i(), 1'b0, 32'd0);
    check("ertn_ex_wb_ex", 32'(bus.wb_ex), 32'd1);
    check("ertn_ex_eret", 32'(bus.eret_flush), 32'd0);
    advance();

    // reset while killing, then a clean commit
    reset_and_check("kill_rst");
    cycle(mk(32'h1C00_0300, CSR_OP_RD, CSR_ERA, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b1), 1'b0, 32'd0);
    drive_check(idle_i(), 1'b0, 32'hDEAD_BEEF);
    check("after_rst_re", 32'(bus.csr_re), 32'd1);
    check("after_rst_rd", bus.rf_wdata_csr, 32'hDEAD_BEEF);
    advance();

    for (int i = 0; i < 1500; i++) begin
      cycle(rnd_instr(), ($urandom_range(0, 11) == 0), $urandom);
    end
    reset_and_check("rst2");
    for (int i = 0; i < 500; i++) begin
      cycle(rnd_instr(), ($urandom_range(0, 7) == 0), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
